match_ctrl: RTL
===============

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 11, points needed to win the match (range 2..15).
REQ-002 SHALL have parameter HOLD_CYC, default 819, cycles the result is held after each point (range 1..1023).
REQ-003 SHALL have parameter SERVE_ALT, default 2, points played between serve changes (range 1..15).
REQ-004 SHALL have these ports: clk  in  1  clock.
REQ-005 SHALL have these ports: reset  in  1  asynchronous, active-low reset; one clock, clk.
REQ-006 SHALL have these ports: start  in  1  one-cycle pulse that begins or restarts a match.
REQ-007 SHALL have these ports: win1, win2  in  1 each  point flags from the game (level, held while the game is in WAIT).
REQ-008 SHALL have these ports: game_state  in  2  game state, with 0=IDLE, 1=LEFT, 2=RIGHT, 3=WAIT.
REQ-009 SHALL have these ports: game_err  in  1  wrong-player serve flag from the game.
REQ-010 SHALL have these ports: game_reset  out  1  synchronous reset to the game.
REQ-011 SHALL have these ports: game_st  out  2  serve select, with 0 = player 1 serves and 1 = player 2 serves.
REQ-012 SHALL have these ports: game_toidle  out  1  return-to-IDLE pulse to the game.
REQ-013 SHALL have these ports: score1, score2  out  4 each  player scores.
REQ-014 SHALL have these ports: match_over  out  1  high while in DONE.
REQ-015 SHALL have these ports: winner  out  2  01 = player 1 won, 10 = player 2 won, 00 = no winner yet.
REQ-016 SHALL have these ports: err_cnt  out  4  count of serve faults.
REQ-017 SHALL have these ports: phase  out  3  current controller state.

Function
REQ-018 SHALL implement these states and phase encodings: M_IDLE=0, M_INIT=1, M_SERVE=2, M_RALLY=3, M_HOLD=4, M_NEXT=5, M_DONE=6.
REQ-019 In M_IDLE, game_reset SHALL be 1; start SHALL move the FSM to M_INIT.
REQ-020 A start pulse in any state SHALL move the FSM to M_INIT next cycle, aborting the current match.
REQ-021 M_INIT SHALL last exactly 1 cycle, with game_reset=1, scores, err_cnt, winner and the point counter cleared, and game_st=0; it SHALL then go to M_SERVE.
REQ-022 In M_SERVE, the FSM SHALL go to M_RALLY when game_state is 1 or 2.
REQ-023 Each game_err high cycle in M_SERVE SHALL increment err_cnt, saturating at 15.
REQ-024 In M_RALLY, win1 SHALL add 1 to score1 and win2 SHALL add 1 to score2, registered on the same edge as the transition to M_HOLD.
REQ-025 Exactly one point SHALL be scored per rally; if win1 and win2 are high together, win1 SHALL take priority.
REQ-026 M_HOLD SHALL count HOLD_CYC cycles and then go to M_DONE if the match is decided, otherwise to M_NEXT.
REQ-027 M_NEXT SHALL last 1 cycle with game_toidle=1, then go to M_SERVE.
REQ-028 game_toidle SHALL be 0 in every state other than M_NEXT.
REQ-029 The match SHALL be decided when a score equals WIN_SCORE (see REQ-036 when DEUCE_EN is defined).
REQ-030 In M_DONE, match_over=1 and winner SHALL be set; only start leaves M_DONE.
REQ-031 Serve rotation: a points-played counter SHALL increment on every point; when it reaches SERVE_ALT, game_st SHALL toggle between 0 and 1 and the counter SHALL clear.
REQ-032 game_st SHALL change only on the M_RALLY-to-M_HOLD edge, never during M_SERVE.
REQ-033 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.

Reset
REQ-034 On reset low, the block SHALL asynchronously enter M_IDLE with game_reset=1, game_toidle=0, game_st=0, score1=score2=0, match_over=0, winner=00, err_cnt=0 and the counters at 0.
REQ-035 Reset SHALL override start.

Configuration
REQ-036 With macro MATCH_DEUCE_EN defined, a win SHALL require score>=WIN_SCORE and a lead of at least 2; when both scores reach WIN_SCORE, both SHALL be set to WIN_SCORE-1; while both are >=WIN_SCORE-1, serve SHALL toggle every point.
REQ-037 With MATCH_DEUCE_EN undefined, the first player to reach WIN_SCORE SHALL win, with no deuce logic present.

Structure
REQ-038 Package match_pkg SHALL hold the phase encodings, game-state constants (G_IDLE, G_LEFT, G_RIGHT, G_WAIT) and serve encodings (ST_P1=0, ST_P2=1).
REQ-039 Serve rotation SHALL be a sub-module serve_rotator, with inputs point, clear and deuce and output st.

Verification (WIN_SCORE=3, HOLD_CYC=4, SERVE_ALT=2)
REQ-040 Release reset, pulse start -> phase 0->1->2, game_reset high in M_IDLE and for the 1 M_INIT cycle, game_st=0.
REQ-041 game_state 0->2, then 3 with win1=1 -> score1=1, phase 4 for 4 cycles, a 1-cycle game_toidle, phase 2.
REQ-042 Two points played (score 1-1) -> game_st=1 from the second point's M_HOLD entry; game_err pulses 3 times in M_SERVE -> err_cnt=3.
REQ-043 Player 1 wins 3-0 -> after the hold, match_over=1, winner=01, phase 6; win1 and win2 high together -> only score1 increments.
REQ-044 MATCH_DEUCE_EN defined, score 2-2, then player 2 scores -> 2-3 with no win; player 1 scores -> scores 2-2, game_st toggles every point; player 2 then scores twice -> winner=10.
REQ-045 start pulse in M_RALLY, and reset low mid-M_HOLD -> M_INIT with scores 0 for the start pulse, and immediate M_IDLE with all outputs at reset values for the reset.

Source files
------------

// File: rtl/match_pkg.sv
// match_pkg: shared encodings for the match controller.
// Phase, game-state, serve and winner constants.
package match_pkg;

   typedef enum logic [2:0] {
      M_IDLE  = 3'd0,
      M_INIT  = 3'd1,
      M_SERVE = 3'd2,
      M_RALLY = 3'd3,
      M_HOLD  = 3'd4,
      M_NEXT  = 3'd5,
      M_DONE  = 3'd6
   } phase_e;

   localparam logic [1:0] G_IDLE  = 2'd0;
   localparam logic [1:0] G_LEFT  = 2'd1;
   localparam logic [1:0] G_RIGHT = 2'd2;
   localparam logic [1:0] G_WAIT  = 2'd3;

   localparam logic ST_P1 = 1'b0;
   localparam logic ST_P2 = 1'b1;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/serve_rotator.sv
// serve_rotator: tracks points played and flips the server.
// Flips every SERVE_ALT points, or every point while deuce is high.
module serve_rotator
   import match_pkg::*;
#(
   parameter int SERVE_ALT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic point,
   input  logic clear,
   input  logic deuce,
   output logic st
);

   localparam logic [3:0] ALT_LAST = 4'(SERVE_ALT - 1);

   logic [3:0] cnt_q;
   logic       st_q;

   // Count points and toggle the server at the rotation boundary.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 4'd0;
         st_q  <= ST_P1;
      end else if (clear) begin
         cnt_q <= 4'd0;
         st_q  <= ST_P1;
      end else if (point) begin
         if (deuce || cnt_q == ALT_LAST) begin
            cnt_q <= 4'd0;
            st_q  <= ~st_q;
         end else begin
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end

   assign st = st_q;

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencing, scoring and serve control for the game.
// Optional deuce play is enabled by defining MATCH_DEUCE_EN.
module match_ctrl
   import match_pkg::*;
#(
   parameter int WIN_SCORE = 11,
   parameter int HOLD_CYC  = 819,
   parameter int SERVE_ALT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       win1,
   input  logic       win2,
   input  logic [1:0] game_state,
   input  logic       game_err,
   output logic       game_reset,
   output logic [1:0] game_st,
   output logic       game_toidle,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       match_over,
   output logic [1:0] winner,
   output logic [3:0] err_cnt,
   output logic [2:0] phase
);

   localparam logic [4:0] W5        = 5'(WIN_SCORE);
   localparam logic [9:0] HOLD_LAST = 10'(HOLD_CYC - 1);

   phase_e     state_q;
   logic [3:0] s1_q, s2_q, err_q;
   logic [9:0] hold_q;
   logic [1:0] pend_q, winner_q;
   logic       rst_game_q, toidle_q, over_q;

   logic [4:0] n1, n2;
   logic [3:0] s1_d, s2_d;
   logic [1:0] pend_d;
   logic       deuce_w, scored, point_w, st_w;

   assign scored  = win1 | win2;
   assign point_w = (state_q == M_RALLY) && scored && !start;

   // Post-point scores, match decision and deuce status.
   always_comb begin
      n1      = {1'b0, s1_q} + {4'd0, win1};
      n2      = {1'b0, s2_q} + {4'd0, ~win1 & win2};
      pend_d  = WIN_NONE;
      deuce_w = 1'b0;
`ifdef MATCH_DEUCE_EN
      if (n1 >= W5 && n1 >= n2 + 5'd2)
         pend_d = WIN_P1;
      else if (n2 >= W5 && n2 >= n1 + 5'd2)
         pend_d = WIN_P2;
      if (n1 == W5 && n2 == W5) begin
         n1 = W5 - 5'd1;
         n2 = W5 - 5'd1;
      end
      deuce_w = (n1 >= W5 - 5'd1) && (n2 >= W5 - 5'd1);
`else
      if (n1 == W5)
         pend_d = WIN_P1;
      else if (n2 == W5)
         pend_d = WIN_P2;
`endif
      s1_d = (n1 > W5) ? W5[3:0] : n1[3:0];
      s2_d = (n2 > W5) ? W5[3:0] : n2[3:0];
   end

   serve_rotator #(
      .SERVE_ALT(SERVE_ALT)
   ) u_rot (
      .clk  (clk),
      .reset(reset),
      .point(point_w),
      .clear(start),
      .deuce(deuce_w),
      .st   (st_w)
   );

   // Match FSM with registered scores and control outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= M_IDLE;
         s1_q       <= 4'd0;
         s2_q       <= 4'd0;
         err_q      <= 4'd0;
         hold_q     <= 10'd0;
         pend_q     <= WIN_NONE;
         winner_q   <= WIN_NONE;
         rst_game_q <= 1'b1;
         toidle_q   <= 1'b0;
         over_q     <= 1'b0;
      end else if (start) begin
         state_q    <= M_INIT;
         s1_q       <= 4'd0;
         s2_q       <= 4'd0;
         err_q      <= 4'd0;
         hold_q     <= 10'd0;
         pend_q     <= WIN_NONE;
         winner_q   <= WIN_NONE;
         rst_game_q <= 1'b1;
         toidle_q   <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         unique case (state_q)
            M_IDLE: ;
            M_INIT: begin
               state_q    <= M_SERVE;
               rst_game_q <= 1'b0;
            end
            M_SERVE: begin
               if (game_err && err_q != 4'd15)
                  err_q <= err_q + 4'd1;
               if (game_state == G_LEFT || game_state == G_RIGHT)
                  state_q <= M_RALLY;
            end
            M_RALLY: begin
               if (scored) begin
                  s1_q    <= s1_d;
                  s2_q    <= s2_d;
                  pend_q  <= pend_d;
                  hold_q  <= 10'd0;
                  state_q <= M_HOLD;
               end
            end
            M_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  if (pend_q != WIN_NONE) begin
                     state_q  <= M_DONE;
                     winner_q <= pend_q;
                     over_q   <= 1'b1;
                  end else begin
                     state_q  <= M_NEXT;
                     toidle_q <= 1'b1;
                  end
               end else begin
                  hold_q <= hold_q + 10'd1;
               end
            end
            M_NEXT: begin
               state_q  <= M_SERVE;
               toidle_q <= 1'b0;
            end
            M_DONE: ;
            default: begin
               state_q    <= M_IDLE;
               rst_game_q <= 1'b1;
               toidle_q   <= 1'b0;
               over_q     <= 1'b0;
            end
         endcase
      end
   end

   assign game_reset  = rst_game_q;
   assign game_st     = {1'b0, st_w};
   assign game_toidle = toidle_q;
   assign score1      = s1_q;
   assign score2      = s2_q;
   assign match_over  = over_q;
   assign winner      = winner_q;
   assign err_cnt     = err_q;
   assign phase       = state_q;

endmodule
